// File: rtl/snake_step_sequencer.sv
// Game-step controller for the snake datapath: divides clk into game ticks and
// sequences direction commit, head move, body shift, apple check and collision scan.
module snake_step_sequencer #(
  parameter int TICK_DIV = 2500000,
  parameter int MAX_LEN  = 20,
  parameter int LEN_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             apple_hit,
  input  logic             seg_hit,
  output logic [1:0]       dir,
  output logic             move_en,
  output logic             shift_en,
  output logic             grow,
  output logic             apple_relocate,
  output logic [LEN_W-1:0] seg_idx,
  output logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             game_over
);

  localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [1:0]       DIR_R   = 2'b00;
  localparam logic [1:0]       DIR_L   = 2'b01;
  localparam logic [1:0]       DIR_U   = 2'b10;
  localparam logic [1:0]       DIR_D   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_MOVE, S_SHIFT, S_APPLE, S_COLLIDE, S_OVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d, pend_q, pend_d;
  logic [LEN_W-1:0] len_q, len_d, seg_q, seg_d;
  logic             grow_pend_q, grow_pend_d;
  logic [1:0]       arb_dir;
  logic             arb_valid;
  logic             tick;

  assign tick = (cnt_q == CNT_MAX);

  // A reversal request is skipped so the next lower-priority button can win.
  always_comb begin
    arb_valid = 1'b1;
    arb_dir   = DIR_R;
    if (right && dir_q != DIR_L)     arb_dir = DIR_R;
    else if (left && dir_q != DIR_R) arb_dir = DIR_L;
    else if (up && dir_q != DIR_D)   arb_dir = DIR_U;
    else if (down && dir_q != DIR_U) arb_dir = DIR_D;
    else                             arb_valid = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    pend_d         = pend_q;
    len_d          = len_q;
    seg_d          = seg_q;
    grow_pend_d    = grow_pend_q;
    move_en        = 1'b0;
    shift_en       = 1'b0;
    grow           = 1'b0;
    apple_relocate = 1'b0;
    busy           = 1'b0;
    game_over      = 1'b0;

    if (state_q != S_IDLE && state_q != S_OVER)
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (arb_valid) pend_d = arb_dir;
        if (tick) begin
          state_d = S_MOVE;
          dir_d   = pend_q;
        end
      end
      S_MOVE: begin
        busy    = 1'b1;
        move_en = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy        = 1'b1;
        shift_en    = 1'b1;
        grow        = grow_pend_q;
        grow_pend_d = 1'b0;
        state_d     = S_APPLE;
      end
      S_APPLE: begin
        busy = 1'b1;
        if (apple_hit) begin
          apple_relocate = 1'b1;
          if (len_q < LEN_MAX) begin
            len_d       = len_q + LEN_W'(1);
            grow_pend_d = 1'b1;
          end
        end
        if (len_d == '0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_COLLIDE;
          seg_d   = LEN_W'(1);
        end
      end
      S_COLLIDE: begin
        busy = 1'b1;
        if (seg_hit) begin
          state_d = S_OVER;
        end else if (seg_q == len_q) begin
          state_d = S_RUN;
          seg_d   = '0;
        end else begin
          seg_d = seg_q + LEN_W'(1);
        end
      end
      S_OVER: begin
        game_over = 1'b1;
        if (start) begin
          state_d     = S_RUN;
          len_d       = '0;
          dir_d       = DIR_R;
          pend_d      = DIR_R;
          grow_pend_d = 1'b0;
          cnt_d       = '0;
          seg_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= DIR_R;
      pend_q      <= DIR_R;
      len_q       <= '0;
      seg_q       <= '0;
      grow_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      seg_q       <= seg_d;
      grow_pend_q <= grow_pend_d;
    end
  end

  assign dir     = dir_q;
  assign length  = len_q;
  assign seg_idx = seg_q;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Randomized scoreboard bench for snake_step_sequencer: a step-level model queues
// the expected outcome of each game step, a monitor checks it when move_en fires.
module tb_snake_step_sequencer;
  localparam int TICK_DIV = 16;
  localparam int MAX_LEN  = 4;
  localparam int LEN_W    = 3;
  localparam int N_RAND   = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic apple_hit = 1'b0;
  logic seg_hit;
  logic [1:0] dir;
  logic move_en, shift_en, grow, apple_relocate, busy, game_over;
  logic [LEN_W-1:0] seg_idx, length;

  int hit_tgt = 0;
  assign seg_hit = (hit_tgt != 0) && (int'(seg_idx) == hit_tgt);

  snake_step_sequencer #(.TICK_DIV(TICK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .up(up), .down(down), .left(left),
    .right(right), .apple_hit(apple_hit), .seg_hit(seg_hit), .dir(dir),
    .move_en(move_en), .shift_en(shift_en), .grow(grow),
    .apple_relocate(apple_relocate), .seg_idx(seg_idx), .length(length),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int dir;
    int grow;
    int reloc;
    int len;
    int scan;
    int over;
  } step_t;

  step_t exp_q[$];
  bit    mon_off = 1'b0;

  // Step-level reference model
  int m_dir = 0, m_pend = 0, m_len = 0, m_gp = 0, m_over = 0, next_move = 0;

  // b = {right, left, up, down}; directions 0 R, 1 L, 2 U, 3 D
  function automatic int arb(input logic [3:0] b, input int d, input int p);
    if (b[3] && d != 1) return 0;
    if (b[2] && d != 0) return 1;
    if (b[1] && d != 3) return 2;
    if (b[0] && d != 2) return 3;
    return p;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dir"}, int'(dir), 0);
    check({tag, "_move_en"}, int'(move_en), 0);
    check({tag, "_shift_en"}, int'(shift_en), 0);
    check({tag, "_grow"}, int'(grow), 0);
    check({tag, "_apple_relocate"}, int'(apple_relocate), 0);
    check({tag, "_seg_idx"}, int'(seg_idx), 0);
    check({tag, "_length"}, int'(length), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
  endtask

  // Called at a negedge; returns at the negedge where the DUT is in its run state.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_dir = 0; m_pend = 0; m_len = 0; m_gp = 0; m_over = 0;
    next_move = cyc + TICK_DIV;
    check("start_game_over", int'(game_over), 0);
    check("start_length", int'(length), 0);
    check("start_dir", int'(dir), 0);
    check("start_busy", int'(busy), 0);
  endtask

  task automatic wait_move_then_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!move_en && n < 40);
    check("move_en_seen", int'(move_en), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 40);
    check("busy_released", int'(busy), 0);
  endtask

  task automatic run_step(input logic [3:0] btn, input int apple, input int hit);
    step_t e;
    {right, left, up, down} = btn;
    apple_hit = (apple != 0);
    hit_tgt   = hit;
    m_pend  = arb(btn, m_dir, m_pend);
    m_dir   = m_pend;
    e.cyc   = next_move;
    e.dir   = m_dir;
    e.grow  = m_gp;
    m_gp    = 0;
    e.reloc = apple;
    if (apple != 0 && m_len < MAX_LEN) begin
      m_len++;
      m_gp = 1;
    end
    e.len = m_len;
    if (m_len == 0) begin
      e.scan = 0; e.over = 0;
    end else if (hit >= 1 && hit <= m_len) begin
      e.scan = hit; e.over = 1;
    end else begin
      e.scan = m_len; e.over = 0;
    end
    m_over = e.over;
    exp_q.push_back(e);
    next_move += TICK_DIV;
    wait_move_then_idle();
  endtask

  task automatic restart_after_over();
    int w;
    w = $urandom_range(2, 10);
    apple_hit = 1'b0;
    hit_tgt   = 0;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      check("over_game_over", int'(game_over), 1);
      check("over_no_move", int'(move_en), 0);
      check("over_length_frozen", int'(length), m_len);
      check("over_dir_frozen", int'(dir), m_dir);
    end
    do_start();
  endtask

  // Monitor: checks one whole step each time move_en is seen
  initial begin
    step_t e;
    forever begin
      @(negedge clk);
      if (move_en && !mon_off) begin
        check("queue_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("move_cycle", cyc, e.cyc);
          check("dir", int'(dir), e.dir);
          check("busy_move", int'(busy), 1);
          @(negedge clk);
          check("shift_en", int'(shift_en), 1);
          check("grow", int'(grow), e.grow);
          check("move_en_one_cycle", int'(move_en), 0);
          @(negedge clk);
          check("apple_relocate", int'(apple_relocate), e.reloc);
          check("shift_en_one_cycle", int'(shift_en), 0);
          @(negedge clk);
          check("length", int'(length), e.len);
          for (int k = 1; k <= e.scan; k++) begin
            if (k > 1) @(negedge clk);
            check("seg_idx", int'(seg_idx), k);
            check("busy_scan", int'(busy), 1);
            check("relocate_one_cycle", int'(apple_relocate), 0);
          end
          if (e.scan > 0) @(negedge clk);
          check("game_over", int'(game_over), e.over);
          check("busy_end", int'(busy), 0);
          if (e.over == 0) check("seg_idx_end", int'(seg_idx), 0);
          $display("step cyc=%0d dir=%0d grow=%0d reloc=%0d len=%0d scan=%0d over=%0d",
                   e.cyc, e.dir, e.grow, e.reloc, e.len, e.scan, e.over);
        end
      end
    end
  end

  // Directed opening: {btn, apple, hit}
  int tbl [0:13][3] = '{
    '{0, 0, 0}, '{6, 0, 0}, '{1, 0, 0}, '{0, 1, 0}, '{0, 1, 0},
    '{0, 1, 0}, '{0, 1, 0}, '{0, 1, 0}, '{0, 0, 0}, '{8, 0, 2},
    '{0, 1, 0}, '{0, 1, 0}, '{0, 1, 0}, '{0, 0, 2}
  };

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_move", int'(move_en), 0);
    check("idle_busy", int'(busy), 0);
    do_start();

    for (int i = 0; i < 14; i++) begin
      if (m_over != 0) restart_after_over();
      run_step(4'(tbl[i][0]), tbl[i][1], tbl[i][2]);
    end

    for (int i = 0; i < N_RAND; i++) begin
      logic [3:0] b;
      int a, h;
      if (m_over != 0) restart_after_over();
      b = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0) ? 1 : 0;
      h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, MAX_LEN)) : 0;
      run_step(b, a, h);
    end

    // Reset asserted in the middle of a collision scan
    if (m_over != 0) restart_after_over();
    run_step(4'b0000, 1, 0);
    mon_off = 1'b1;
    apple_hit = 1'b0;
    hit_tgt = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && seg_idx == 1) && n < 40);
    check("scan_reached", int'(seg_idx), 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midstep_reset");
    rst = 1'b1;
    repeat (TICK_DIV + 4) @(negedge clk);
    check("post_reset_idle_no_move", int'(move_en), 0);
    mon_off = 1'b0;
    do_start();
    run_step(4'b0100, 0, 0);
    run_step(4'b0010, 1, 0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 500000", $time);
    $fatal(1);
  end

endmodule
